lif_spike_encoder: RTL
======================

# lif_spike_encoder

Leaky integrate-and-fire neuron that turns a stream of 8-bit sensor intensity samples into single-cycle spikes. It sits directly upstream of the actuator driver and drives that block's `spike_in`. A valid/ready handshake accepts samples. Leak, threshold and refractory period are fixed per instance by parameters.

## Interface
- `POT_W`, 12: membrane potential width (unsigned).
- `THRESHOLD`, 200: fire when the updated potential is ≥ this value. Legal range 1 .. 2^POT_W−1.
- `LEAK_SHIFT`, 3: leak per cycle is `v >> LEAK_SHIFT`. Legal range 1 .. POT_W−1.
- `REFRACT_CYCLES`, 4: dead cycles after the FIRE cycle. 0 means no refractory period. Legal range 0..255.
- `clk` input 1: clock, all logic on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `sample_valid` input 1: `sample_data` is valid.
- `sample_data` input 8: unsigned intensity.
- `sample_ready` output 1: block can accept a sample. Combinational from state; high only in INTEGRATE.
- `spike_out` output 1: registered one-cycle spike pulse.
- `membrane` output POT_W: current potential (registered).
- `refractory` output 1: high in FIRE and REFRACT.
- `spike_count` output 16: total spikes since reset; saturates at 0xFFFF.

## Operation
- States: INTEGRATE, FIRE, REFRACT.
- Reset state: INTEGRATE.
- Reset values: `membrane` = 0, `spike_out` = 0, `spike_count` = 0, refractory counter = 0, `refractory` = 0.
- INTEGRATE, every cycle:
  - `acc = v − (v >> LEAK_SHIFT) + (accept ? sample_data : 0)`, where `accept = sample_valid & sample_ready`.
  - `acc` is computed at POT_W+1 bits and clamped to 2^POT_W−1.
  - Leak applies in every INTEGRATE cycle, including cycles with no sample.
- Fire condition: `acc ≥ THRESHOLD`. Then, at the same edge:
  - `membrane` ← 0.
  - `spike_out` ← 1.
  - `spike_count` increments (saturating).
  - state → FIRE.
- Otherwise: `membrane` ← `acc`, `spike_out` ← 0.
- FIRE (exactly 1 cycle):
  - `sample_ready` = 0; `membrane` held at 0.
  - `spike_out` ← 0 at the exiting edge.
  - Next state is REFRACT with counter loaded to REFRACT_CYCLES. If REFRACT_CYCLES = 0, next state is INTEGRATE.
- REFRACT:
  - `sample_ready` = 0; `membrane` held at 0, no leak and no input.
  - Counter decrements each cycle; on the cycle it reads 1, next state is INTEGRATE.
- Upstream holds `sample_valid` and `sample_data` stable until accepted. A sample presented while `sample_ready` = 0 is not consumed, and no data is lost.
- `spike_out` is never high on two consecutive cycles.

## Timing
- Sample accepted at edge N:
  - `membrane` reflects it after edge N.
  - If it causes a fire, `spike_out` is high from edge N to edge N+1.
- After a fire accepted at edge N, `sample_ready` returns high after edge N+1+REFRACT_CYCLES. Default: low for 5 cycles.
- Reset asserted mid-FIRE or mid-REFRACT: all outputs return to reset values immediately (asynchronous). Operation restarts in INTEGRATE after `rst` deasserts.
- Fire has priority over the clamp: a clamped `acc` that is ≥ THRESHOLD fires.

## Structure
- Shared package `rpu_pkg`:
  - state enum `lif_state_t` (INTEGRATE, FIRE, REFRACT).
  - `SPIKE_CNT_W` = 16.
  - `SAMPLE_W` = 8.
- One sub-module, `refractory_timer`:
  - inputs: load pulse, load value.
  - outputs: `busy`, `done` (8-bit down-counter).
- The FSM, leak/accumulate datapath and spike counter stay in `lif_spike_encoder`.

## Test plan
- Integrate-and-fire (defaults): from reset, present 100 on three consecutive cycles with `sample_valid` = 1.
  - `membrane` goes 100, then 188, then the third sample fires (acc 265 ≥ 200).
  - `spike_out` is high for exactly 1 cycle; `membrane` = 0; `spike_count` = 1.
- Leak only: load 100, then hold `sample_valid` = 0.
  - `membrane` goes 88, 77, 68, 60 and decays to 7 (7 >> 3 = 0), where it holds.
  - No spike.
- Refractory backpressure: fire, keep `sample_valid` = 1 with data 50.
  - `sample_ready` is low for 5 cycles and `refractory` is high for 5 cycles.
  - The held sample is accepted on the first INTEGRATE cycle; `membrane` = 50.
- Single-sample fire: present 255 from 0.
  - Immediate fire; `membrane` = 0; no second spike on the following cycle.
- REFRACT_CYCLES = 0 instance: fire.
  - `sample_ready` is low for exactly 1 cycle (FIRE only), then high.
- Reset mid-REFRACT: assert `rst` 2 cycles into REFRACT.
  - `spike_out`, `membrane`, `spike_count` and `refractory` are all 0 immediately.
  - After deassert, `sample_ready` = 1 on the next cycle.

Source files
------------

// File: rtl/rpu_pkg.sv
// Shared types and widths for the spike-processing blocks.
package rpu_pkg;

    localparam int SPIKE_CNT_W = 16;
    localparam int SAMPLE_W    = 8;

    typedef enum logic [1:0] {
        INTEGRATE,
        FIRE,
        REFRACT
    } lif_state_t;

endpackage

// File: rtl/refractory_timer.sv
// 8-bit loadable down-counter that times the dead period after a spike.
module refractory_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       busy,
    output logic       done
);

    logic [7:0] count_q;

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != 8'd0) begin
            count_q <= count_q - 8'd1;
        end
    end

    assign busy = (count_q != 8'd0);
    // done marks the last dead cycle, so the FSM leaves REFRACT at the following edge.
    assign done = (count_q == 8'd1);

endmodule

// File: rtl/lif_spike_encoder.sv
// Leaky integrate-and-fire neuron: integrates 8-bit samples, leaks every cycle, emits one-cycle spikes.
module lif_spike_encoder
    import rpu_pkg::*;
#(
    parameter int POT_W          = 12,
    parameter int THRESHOLD      = 200,
    parameter int LEAK_SHIFT     = 3,
    parameter int REFRACT_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_valid,
    input  logic [SAMPLE_W-1:0]    sample_data,
    output logic                   sample_ready,
    output logic                   spike_out,
    output logic [POT_W-1:0]       membrane,
    output logic                   refractory,
    output logic [SPIKE_CNT_W-1:0] spike_count
);

    lif_state_t             state_q, state_d;
    logic [POT_W-1:0]       membrane_d;
    logic                   spike_d;
    logic [SPIKE_CNT_W-1:0] count_d;
    logic                   timer_load, timer_busy, timer_done;
    logic                   accept;
    logic [POT_W-1:0]       leak;
    logic [POT_W:0]         acc_full;
    logic [POT_W-1:0]       acc_sat;

    refractory_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (8'(REFRACT_CYCLES)),
        .busy     (timer_busy),
        .done     (timer_done)
    );

    assign sample_ready = (state_q == INTEGRATE);
    assign refractory   = (state_q == FIRE) || (state_q == REFRACT);
    assign accept       = sample_valid && sample_ready;

    // One extra bit of headroom so the sum cannot wrap before it is clamped.
    assign leak     = membrane >> LEAK_SHIFT;
    assign acc_full = {1'b0, membrane} - {1'b0, leak}
                    + (accept ? (POT_W+1)'(sample_data) : '0);
    assign acc_sat  = acc_full[POT_W] ? '1 : acc_full[POT_W-1:0];

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        membrane_d = membrane;
        spike_d    = 1'b0;
        count_d    = spike_count;
        timer_load = 1'b0;
        case (state_q)
            INTEGRATE: begin
                if (acc_sat >= POT_W'(THRESHOLD)) begin
                    membrane_d = '0;
                    spike_d    = 1'b1;
                    count_d    = (spike_count == '1) ? spike_count : spike_count + 1'b1;
                    state_d    = FIRE;
                end else begin
                    membrane_d = acc_sat;
                end
            end
            FIRE: begin
                membrane_d = '0;
                if (REFRACT_CYCLES == 0) begin
                    state_d = INTEGRATE;
                end else begin
                    timer_load = 1'b1;
                    state_d    = REFRACT;
                end
            end
            REFRACT: begin
                membrane_d = '0;
                if (timer_done || !timer_busy) state_d = INTEGRATE;
            end
            default: state_d = INTEGRATE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INTEGRATE;
            membrane    <= '0;
            spike_out   <= 1'b0;
            spike_count <= '0;
        end else begin
            state_q     <= state_d;
            membrane    <= membrane_d;
            spike_out   <= spike_d;
            spike_count <= count_d;
        end
    end

endmodule
